icache_refill: RTL and testbench

Refill engine that owns the write side of the I-cache data array. On a miss it accepts one line-aligned request, fetches the cache block from the memory side as a fixed number of beats, assembles the full block in a line buffer, and issues exactly one write into the data array's refill port. It sits between the I-cache miss logic and the lower memory interface; one refill is outstanding at a time.

---
 rtl/icache_refill.sv | 132 +++++++++++++
 tb/tb_icache_refill.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// I-cache refill engine: one miss -> one line request -> NUM_BEATS beats -> one data-array write (write 2+NUM_BEATS cycles after accept, no stalls).
// Backpressure: miss_ready_o only in IDLE, stalls on mem_req_ready_i/mem_rsp_valid_i; ICACHE_REFILL_ERR_EN adds beat error reporting.
module icache_refill #(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 4,
  parameter int SETS_PER_BANK_WIDTH = 8,
  parameter int BLOCK_WIDTH         = 512,
  parameter int BEAT_WIDTH          = 64,
  parameter int ADDR_WIDTH          = 32,
  localparam int NUM_BEATS = BLOCK_WIDTH / BEAT_WIDTH,
  localparam int OFS_W     = $clog2(BLOCK_WIDTH / 8),
  localparam int BSEL_W    = $clog2(NUM_BANKS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
  input  logic [NUM_WAYS-1:0]            miss_way_i,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  output logic                           mem_rsp_ready_o,
  input  logic [BEAT_WIDTH-1:0]          mem_rsp_data_i,
  output logic [SETS_PER_BANK_WIDTH-1:0] w_bank_addr_o,
  output logic [BSEL_W-1:0]              w_bank_sel_o,
  output logic [NUM_WAYS-1:0]            we_way_mask_o,
  output logic [BLOCK_WIDTH-1:0]         wdata_o,
`ifdef ICACHE_REFILL_ERR_EN
  input  logic                           mem_rsp_err_i,
  output logic                           refill_err_o,
`endif
  output logic                           refill_done_o
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'((BLOCK_WIDTH / 8) - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [NUM_WAYS-1:0]     way_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [BLOCK_WIDTH-1:0]  line_q;
  logic                    accept;
  logic                    beat;
  logic                    last_beat;
  logic                    wr_block;

  assign accept    = (state_q == IDLE) && miss_valid_i;
  assign beat      = (state_q == RECV) && mem_rsp_valid_i;
  assign last_beat = beat && (cnt_q == LAST_BEAT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    we_way_mask_o   = '0;
    refill_done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) state_d = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = RECV;
      end
      RECV: begin
        mem_rsp_ready_o = 1'b1;
        if (last_beat) state_d = WRITE;
      end
      WRITE: begin
        refill_done_o = 1'b1;
        if (!wr_block) we_way_mask_o = way_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      way_q  <= '0;
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= miss_addr_i & ~OFS_MASK;
        way_q  <= miss_way_i;
        cnt_q  <= '0;
      end
      if (beat) begin
        // Beat k lands at bits [k*BEAT_WIDTH +: BEAT_WIDTH]; beat 0 is the LSBs.
        line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
        cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
      end
    end
  end

`ifdef ICACHE_REFILL_ERR_EN
  logic err_q;

  // Sticky across the whole refill; remaining beats are still drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     err_q <= 1'b0;
    else if (accept)                 err_q <= 1'b0;
    else if (beat && mem_rsp_err_i)  err_q <= 1'b1;
  end

  assign wr_block     = err_q;
  assign refill_err_o = (state_q == WRITE) && err_q;
`else
  assign wr_block = 1'b0;
`endif

  assign mem_req_addr_o = addr_q;
  assign w_bank_addr_o  = addr_q[OFS_W+BSEL_W +: SETS_PER_BANK_WIDTH];
  assign w_bank_sel_o   = addr_q[OFS_W +: BSEL_W];
  assign wdata_o        = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed refills with literal expectations plus randomized traffic checked every cycle against a transaction-level model.
module tb_icache_refill;
  localparam int NB = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic [3:0]   miss_way_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;
  logic [63:0]  mem_rsp_data_i;
  logic [7:0]   w_bank_addr_o;
  logic [1:0]   w_bank_sel_o;
  logic [3:0]   we_way_mask_o;
  logic [511:0] wdata_o;
  logic         refill_done_o;
  logic         rsp_err;
  logic         err_out;

  always #5 clk_i = ~clk_i;

  icache_refill dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr_i), .miss_way_i(miss_way_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_data_i(mem_rsp_data_i),
    .w_bank_addr_o(w_bank_addr_o), .w_bank_sel_o(w_bank_sel_o),
    .we_way_mask_o(we_way_mask_o), .wdata_o(wdata_o),
`ifdef ICACHE_REFILL_ERR_EN
    .mem_rsp_err_i(rsp_err), .refill_err_o(err_out),
`endif
    .refill_done_o(refill_done_o)
  );

`ifndef ICACHE_REFILL_ERR_EN
  assign err_out = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding refill, a queue of accepted beats.
  bit          busy = 0;
  bit          req_sent = 0;
  bit          m_err = 0;
  logic [31:0] m_addr = '0;
  logic [3:0]  m_way = '0;
  logic [63:0] mq[$];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      busy = 0; req_sent = 0; m_err = 0; mq.delete();
    end else if (!busy) begin
      if (miss_valid_i) begin
        busy = 1; req_sent = 0; m_err = 0; mq.delete();
        m_addr = miss_addr_i; m_way = miss_way_i;
      end
    end else if (mq.size() == NB) begin
      busy = 0;
    end else if (!req_sent) begin
      if (mem_req_ready_i) req_sent = 1;
    end else if (mem_rsp_valid_i) begin
      mq.push_back(mem_rsp_data_i);
      if (rsp_err) m_err = 1;
    end
  end

  always @(negedge clk_i) begin : cmp
    logic [511:0] blk;
    logic [31:0]  line;
    bit           wr;
    logic [3:0]   emask;
    if (refill_done_o) done_cnt++;
    if (we_way_mask_o != 0) wr_cnt++;
    if (!rst_ni) begin
      chk("rst_miss_ready", miss_ready_o, 1);
      chk("rst_req_valid", mem_req_valid_o, 0);
      chk("rst_rsp_ready", mem_rsp_ready_o, 0);
      chk("rst_mask", we_way_mask_o, 0);
      chk("rst_done", refill_done_o, 0);
      chk("rst_err", err_out, 0);
      chk("rst_wdata", wdata_o, 0);
      chk("rst_req_addr", mem_req_addr_o, 0);
    end else begin
      wr    = busy && (mq.size() == NB);
      emask = (wr && !m_err) ? m_way : 4'd0;
      line  = m_addr - (m_addr % 64);
      chk("miss_ready", miss_ready_o, !busy);
      chk("req_valid", mem_req_valid_o, busy && !req_sent);
      chk("rsp_ready", mem_rsp_ready_o, busy && req_sent && (mq.size() < NB));
      chk("done", refill_done_o, wr);
      chk("mask", we_way_mask_o, emask);
      chk("err", err_out, wr && m_err);
      if (busy && !req_sent) chk("req_addr", mem_req_addr_o, line);
      if (emask != 0) begin
        blk = '0;
        for (int k = 0; k < NB; k++) blk[k*64 +: 64] = mq[k];
        chk("wdata", wdata_o, blk);
        chk("bank_sel", w_bank_sel_o, (line / 64) % 4);
        chk("bank_addr", w_bank_addr_o, (line / 256) % 256);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one refill; returns cycles from accept edge to the sampled done cycle.
  task automatic run_refill(input logic [31:0] addr, input logic [3:0] way, input int req_wait,
                            input int gap_at, input int gap_len, input int err_beat,
                            output int lat, output logic [31:0] raddr);
    int n;
    miss_valid_i = 1; miss_addr_i = addr; miss_way_i = way;
    step();
    miss_valid_i = 0;
    raddr = mem_req_addr_o;
    lat = 1;
    mem_req_ready_i = 0;
    repeat (req_wait) begin step(); lat++; end
    mem_req_ready_i = 1;
    step(); lat++;
    mem_req_ready_i = 0;
    for (int k = 0; k < NB; k++) begin
      if (k == gap_at) repeat (gap_len) begin mem_rsp_valid_i = 0; step(); lat++; end
      mem_rsp_valid_i = 1; mem_rsp_data_i = 64'(k); rsp_err = (k == err_beat);
      step(); lat++;
    end
    mem_rsp_valid_i = 0; rsp_err = 0;
    n = 0;
    while (!refill_done_o && n < 20) begin step(); lat++; n++; end
    chk("done_seen", refill_done_o, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] pat;
    logic [31:0]  ra;
    int           lat;
    int           d0;
    int           w0;
    pat = '0;
    for (int k = 0; k < NB; k++) pat[k*64 +: 64] = 64'(k);

    rst_ni = 0; miss_valid_i = 0; miss_addr_i = 0; miss_way_i = 0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rsp_data_i = 0; rsp_err = 0;
    repeat (3) step();
    chk("reset_miss_ready", miss_ready_o, 1);
    chk("reset_mask", we_way_mask_o, 0);
    rst_ni = 1;
    step();

    // Basic refill, no stalls
    run_refill(32'h8000_1240, 4'b0010, 0, -1, 0, -1, lat, ra);
    chk("t1_req_addr", ra, 32'h8000_1240);
    chk("t1_latency", lat, 10);
    chk("t1_mask", we_way_mask_o, 4'b0010);
    chk("t1_sel", w_bank_sel_o, 1);
    chk("t1_idx", w_bank_addr_o, 8'h12);
    chk("t1_wdata", wdata_o, pat);
    step();
    chk("t1_ready_back", miss_ready_o, 1);

    // Request stall and beat gap
    d0 = done_cnt;
    run_refill(32'h8000_1240, 4'b0010, 3, 4, 2, -1, lat, ra);
    chk("t2_latency", lat, 15);
    chk("t2_wdata", wdata_o, pat);
    chk("t2_mask", we_way_mask_o, 4'b0010);
    step(); step();
    chk("t2_one_done", done_cnt - d0, 1);

    // Second miss held during a refill
    w0 = wr_cnt;
    miss_valid_i = 1; miss_addr_i = 32'h0000_0100; miss_way_i = 4'b0001;
    step();
    miss_addr_i = 32'h1234_5678; miss_way_i = 4'b1000;
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    for (int k = 0; k < NB; k++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = {32'hA5A5_0000, 32'(k)}; step();
    end
    mem_rsp_valid_i = 0;
    chk("t3_write_busy", miss_ready_o, 0);
    chk("t3_write_done", refill_done_o, 1);
    step();
    chk("t3_ready_after", miss_ready_o, 1);
    step();
    miss_valid_i = 0;
    chk("t3_second_req", mem_req_valid_o, 1);
    chk("t3_second_addr", mem_req_addr_o, 32'h1234_5640);
    chk("t3_one_write", wr_cnt - w0, 1);
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    for (int k = 0; k < NB; k++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 64'(k * 3); step();
    end
    mem_rsp_valid_i = 0;
    step(); step();

    // Reset mid-refill
    w0 = wr_cnt;
    miss_valid_i = 1; miss_addr_i = 32'h0000_0040; miss_way_i = 4'b0100;
    step();
    miss_valid_i = 0;
    mem_req_ready_i = 1; step(); mem_req_ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      mem_rsp_valid_i = 1; mem_rsp_data_i = 64'hFFFF_0000 + 64'(k); step();
    end
    mem_rsp_valid_i = 0;
    rst_ni = 0;
    #1;
    chk("t4_miss_ready", miss_ready_o, 1);
    chk("t4_rsp_ready", mem_rsp_ready_o, 0);
    chk("t4_wdata", wdata_o, 0);
    chk("t4_bank_addr", w_bank_addr_o, 0);
    chk("t4_bank_sel", w_bank_sel_o, 0);
    step();
    rst_ni = 1;
    step();
    chk("t4_no_write", wr_cnt - w0, 0);
    run_refill(32'h0000_0040, 4'b0100, 0, -1, 0, -1, lat, ra);
    chk("t4_latency", lat, 10);
    chk("t4_mask", we_way_mask_o, 4'b0100);
    chk("t4_wdata", wdata_o, pat);
    step();

    // Unaligned top-of-range address
    run_refill(32'h8000_FFFF, 4'b0001, 0, -1, 0, -1, lat, ra);
    chk("t5_req_addr", ra, 32'h8000_FFC0);
    chk("t5_sel", w_bank_sel_o, 3);
    chk("t5_idx", w_bank_addr_o, 8'hFF);
    step();

`ifdef ICACHE_REFILL_ERR_EN
    run_refill(32'h8000_1240, 4'b0010, 0, -1, 0, 2, lat, ra);
    chk("t6_latency", lat, 10);
    chk("t6_err", err_out, 1);
    chk("t6_mask", we_way_mask_o, 0);
    step();
    run_refill(32'h8000_1240, 4'b0010, 0, -1, 0, -1, lat, ra);
    chk("t6_err_cleared", err_out, 0);
    chk("t6_mask_after", we_way_mask_o, 4'b0010);
    step();
`endif

    // Randomized traffic
    d0 = done_cnt;
    for (int c = 0; c < 3000; c++) begin
      miss_valid_i    = ($urandom % 4) == 0;
      miss_addr_i     = $urandom;
      miss_way_i      = (($urandom % 4) == 0) ? 4'($urandom) : 4'(1 << ($urandom % 4));
      mem_req_ready_i = ($urandom % 2) == 1;
      mem_rsp_valid_i = ($urandom % 10) < 7;
      mem_rsp_data_i  = {$urandom, $urandom};
`ifdef ICACHE_REFILL_ERR_EN
      rsp_err = ($urandom % 16) == 0;
`endif
      step();
    end
    miss_valid_i = 0; rsp_err = 0;
    mem_req_ready_i = 1; mem_rsp_valid_i = 1;
    repeat (20) step();
    mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    step();
    chk("rand_refills_seen", done_cnt > d0 + 20, 1);
    chk("rand_idle_end", miss_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
